// File: rtl/sprite_pixel_composer.sv
// Resolves one pixel colour from four streamed sprite candidates by fetching texels front-most layer first.
// Optional build macro SPRITE_BORDER_EN: draws sprite bounding boxes in BORDER_COLOR.
module sprite_pixel_composer #(
    parameter int unsigned        COLOR_W      = 9,
    parameter logic [COLOR_W-1:0] TRANSPARENT  = 9'h000,
    parameter logic [COLOR_W-1:0] BG_COLOR     = 9'h000,
    parameter logic [COLOR_W-1:0] BORDER_COLOR = 9'h1FF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cand_start,
    input  logic [5:0]         cand_id,
    input  logic [9:0]         cand_x,
    input  logic [9:0]         cand_y,
    input  logic [5:0]         cand_layer,
    input  logic [9:0]         h_pos,
    input  logic [9:0]         v_pos,
    output logic               rom_rd,
    output logic [13:0]        rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               pixel_valid,
    output logic [COLOR_W-1:0] pixel_color,
    output logic               pixel_hit,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [9:0]         h_q, h_d, v_q, v_d;
    logic [3:0][5:0]    slot_id_q, slot_id_d;
    logic [3:0][5:0]    slot_layer_q, slot_layer_d;
    logic [3:0][3:0]    slot_row_q, slot_row_d;
    logic [3:0][3:0]    slot_col_q, slot_col_d;
    logic [3:0]         elig_q, elig_d;
    logic [1:0]         sel_q, sel_d;
    logic               rom_rd_q, rom_rd_d;
    logic [13:0]        rom_addr_q, rom_addr_d;
    logic               pixel_valid_q, pixel_valid_d;
    logic [COLOR_W-1:0] pixel_color_q, pixel_color_d;
    logic               pixel_hit_q, pixel_hit_d;
    logic               busy_q, busy_d;

    logic [9:0]         cap_h_s, cap_v_s;
    logic [10:0]        dx_s, dy_s;
    logic               cap_elig_s;
    logic [1:0]         cap_idx_s;
    logic               tex_hit_s;
    logic [COLOR_W-1:0] tex_color_s;
    logic [2:0]         pick_s;

    // Lowest layer wins; strict compare keeps ties on the lower slot index. Returns {found, index}.
    function automatic logic [2:0] pick_slot(input logic [3:0] elig, input logic [3:0][5:0] layer);
        logic       found;
        logic [1:0] idx;
        logic [5:0] best;
        found = 1'b0;
        idx   = 2'd0;
        best  = 6'd0;
        for (int i = 0; i < 4; i++) begin
            if (elig[i] && (!found || (layer[i] < best))) begin
                found = 1'b1;
                idx   = 2'(i);
                best  = layer[i];
            end
        end
        return {found, idx};
    endfunction

`ifdef SPRITE_BORDER_EN
    function automatic logic on_edge(input logic [3:0] row, input logic [3:0] col);
        return (row == 4'd0) || (row == 4'd15) || (col == 4'd0) || (col == 4'd15);
    endfunction
`else
    logic unused_border_s;
    assign unused_border_s = ^BORDER_COLOR;
`endif

    // Window test for the entry on the bus; entry 0 uses the live pixel position, later entries the latched one.
    always_comb begin
        if (state_q == S_IDLE) begin
            cap_h_s = h_pos;
            cap_v_s = v_pos;
        end else begin
            cap_h_s = h_q;
            cap_v_s = v_q;
        end
        dx_s       = {1'b0, cap_h_s} - {1'b0, cand_x};
        dy_s       = {1'b0, cap_v_s} - {1'b0, cand_y};
        cap_elig_s = (cand_id != 6'h3F) && (dx_s[10:4] == 7'd0) && (dy_s[10:4] == 7'd0);
        cap_idx_s  = cnt_q + 2'd1;
    end

    // Texel verdict for the slot currently being checked.
    always_comb begin
`ifdef SPRITE_BORDER_EN
        if (on_edge(slot_row_q[sel_q], slot_col_q[sel_q])) begin
            tex_hit_s   = 1'b1;
            tex_color_s = BORDER_COLOR;
        end else begin
            tex_hit_s   = (rom_data != TRANSPARENT);
            tex_color_s = rom_data;
        end
`else
        tex_hit_s   = (rom_data != TRANSPARENT);
        tex_color_s = rom_data;
`endif
    end

    // Next-state, slot capture and registered output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        h_d           = h_q;
        v_d           = v_q;
        slot_id_d     = slot_id_q;
        slot_layer_d  = slot_layer_q;
        slot_row_d    = slot_row_q;
        slot_col_d    = slot_col_q;
        elig_d        = elig_q;
        sel_d         = sel_q;
        rom_addr_d    = rom_addr_q;
        pixel_color_d = pixel_color_q;
        pixel_hit_d   = pixel_hit_q;

        case (state_q)
            S_IDLE: begin
                if (cand_start) begin
                    h_d             = h_pos;
                    v_d             = v_pos;
                    slot_id_d[0]    = cand_id;
                    slot_layer_d[0] = cand_layer;
                    slot_row_d[0]   = dy_s[3:0];
                    slot_col_d[0]   = dx_s[3:0];
                    elig_d          = {3'b000, cap_elig_s};
                    cnt_d           = 2'd0;
                    state_d         = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                slot_id_d[cap_idx_s]    = cand_id;
                slot_layer_d[cap_idx_s] = cand_layer;
                slot_row_d[cap_idx_s]   = dy_s[3:0];
                slot_col_d[cap_idx_s]   = dx_s[3:0];
                elig_d[cap_idx_s]       = cap_elig_s;
                cnt_d                   = cap_idx_s;
                if (cnt_q == 2'd2) begin
                    if (|elig_d) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d       = S_DONE;
                        pixel_color_d = BG_COLOR;
                        pixel_hit_d   = 1'b0;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_FETCH: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (tex_hit_s) begin
                    state_d       = S_DONE;
                    pixel_color_d = tex_color_s;
                    pixel_hit_d   = 1'b1;
                end else begin
                    elig_d[sel_q] = 1'b0;
                    if (|elig_d) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d       = S_DONE;
                        pixel_color_d = BG_COLOR;
                        pixel_hit_d   = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                elig_d  = 4'b0000;
            end
        endcase

        // Selection runs on next-cycle slot contents so the read strobe and address are flops.
        pick_s = pick_slot(elig_d, slot_layer_d);
        if ((state_d == S_FETCH) && pick_s[2]) begin
            rom_rd_d   = 1'b1;
            sel_d      = pick_s[1:0];
            rom_addr_d = {slot_id_d[pick_s[1:0]], slot_row_d[pick_s[1:0]], slot_col_d[pick_s[1:0]]};
        end else begin
            rom_rd_d = 1'b0;
        end
        pixel_valid_d = (state_d == S_DONE);
        busy_d        = (state_d != S_IDLE);
    end

    // State, slot and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 2'd0;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            slot_id_q     <= '0;
            slot_layer_q  <= '0;
            slot_row_q    <= '0;
            slot_col_q    <= '0;
            elig_q        <= 4'b0000;
            sel_q         <= 2'd0;
            rom_rd_q      <= 1'b0;
            rom_addr_q    <= 14'd0;
            pixel_valid_q <= 1'b0;
            pixel_color_q <= '0;
            pixel_hit_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            h_q           <= h_d;
            v_q           <= v_d;
            slot_id_q     <= slot_id_d;
            slot_layer_q  <= slot_layer_d;
            slot_row_q    <= slot_row_d;
            slot_col_q    <= slot_col_d;
            elig_q        <= elig_d;
            sel_q         <= sel_d;
            rom_rd_q      <= rom_rd_d;
            rom_addr_q    <= rom_addr_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_color_q <= pixel_color_d;
            pixel_hit_q   <= pixel_hit_d;
            busy_q        <= busy_d;
        end
    end

    assign rom_rd      = rom_rd_q;
    assign rom_addr    = rom_addr_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_color = pixel_color_q;
    assign pixel_hit   = pixel_hit_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sprite_pixel_composer.sv
// Randomized bench for sprite_pixel_composer with a sort-based reference model and a per-cycle compare process.
module tb_sprite_pixel_composer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cand_start;
    logic [5:0]  cand_id;
    logic [9:0]  cand_x;
    logic [9:0]  cand_y;
    logic [5:0]  cand_layer;
    logic [9:0]  h_pos;
    logic [9:0]  v_pos;
    logic        rom_rd;
    logic [13:0] rom_addr;
    logic [8:0]  rom_data = 9'h000;
    logic        pixel_valid;
    logic [8:0]  pixel_color;
    logic        pixel_hit;
    logic        busy;

    sprite_pixel_composer dut (
        .clk(clk), .rst(rst), .cand_start(cand_start), .cand_id(cand_id),
        .cand_x(cand_x), .cand_y(cand_y), .cand_layer(cand_layer),
        .h_pos(h_pos), .v_pos(v_pos), .rom_rd(rom_rd), .rom_addr(rom_addr),
        .rom_data(rom_data), .pixel_valid(pixel_valid), .pixel_color(pixel_color),
        .pixel_hit(pixel_hit), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [8:0] rom_mem [0:16383];
    always @(posedge clk) if (rom_rd) rom_data <= rom_mem[rom_addr];

    int cycle_n = 0;
    always @(posedge clk) cycle_n <= cycle_n + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cycle_n);
        end
    endtask

    // candidate set for the next transaction
    logic [5:0] c_id [4];
    logic [9:0] c_x [4];
    logic [9:0] c_y [4];
    logic [5:0] c_layer [4];
    logic [9:0] c_h, c_v;

    // model expectations and what the compare process observed
    bit          active = 1'b0;
    int          start_cyc;
    int          exp_nrd, exp_done;
    logic [13:0] exp_addr [4];
    logic [8:0]  exp_color;
    logic        exp_hit;
    int          seen_rd, seen_done;
    logic [13:0] seen_addr [4];
    logic [8:0]  seen_color;
    logic        seen_hit;

    always @(negedge clk) begin
        int rel;
        bit erd;
        if (active) begin
            rel = cycle_n - start_cyc;
            erd = (rel >= 4) && (rel < 4 + 2 * exp_nrd) && (((rel - 4) % 2) == 0);
            check("rom_rd", 32'(rom_rd), 32'(erd));
            if (rom_rd && seen_rd < 4) begin
                seen_addr[seen_rd] = rom_addr;
                seen_rd++;
            end
            if (erd) check("rom_addr", 32'(rom_addr), 32'(exp_addr[(rel - 4) / 2]));
            check("pixel_valid", 32'(pixel_valid), 32'(rel == exp_done));
            check("busy", 32'(busy), 32'((rel >= 1) && (rel <= exp_done)));
            if (pixel_valid) begin
                seen_done  = rel;
                seen_color = pixel_color;
                seen_hit   = pixel_hit;
            end
            if (rel == exp_done) begin
                check("pixel_color", 32'(pixel_color), 32'(exp_color));
                check("pixel_hit", 32'(pixel_hit), 32'(exp_hit));
                active = 1'b0;
            end
        end
    end

    task automatic build_model();
        bit el [4];
        bit used [4];
        int ord [$];
        int best, dx, dy, nf;
        logic [13:0] a;
        logic [8:0] tex;
        bit border;
        for (int k = 0; k < 4; k++) begin
            dx = int'(c_h) - int'(c_x[k]);
            dy = int'(c_v) - int'(c_y[k]);
            el[k] = (c_id[k] != 6'h3F) && dx >= 0 && dx <= 15 && dy >= 0 && dy <= 15;
            used[k] = 1'b0;
        end
        while (1) begin
            best = -1;
            for (int k = 0; k < 4; k++)
                if (el[k] && !used[k] && (best < 0 || c_layer[k] < c_layer[best])) best = k;
            if (best < 0) break;
            used[best] = 1'b1;
            ord.push_back(best);
        end
        exp_hit = 1'b0;
        exp_color = 9'h000;
        nf = 0;
        foreach (ord[j]) begin
            dx = int'(c_h) - int'(c_x[ord[j]]);
            dy = int'(c_v) - int'(c_y[ord[j]]);
            a = {c_id[ord[j]], 4'(dy), 4'(dx)};
            exp_addr[nf] = a;
            nf++;
            tex = rom_mem[a];
            border = 1'b0;
`ifdef SPRITE_BORDER_EN
            border = (dx == 0) || (dx == 15) || (dy == 0) || (dy == 15);
`endif
            if (border) begin
                exp_hit = 1'b1;
                exp_color = 9'h1FF;
                break;
            end else if (tex != 9'h000) begin
                exp_hit = 1'b1;
                exp_color = tex;
                break;
            end
        end
        exp_nrd = nf;
        exp_done = 4 + 2 * nf;
    endtask

    task automatic drive_entry(input int k);
        cand_id    = c_id[k];
        cand_x     = c_x[k];
        cand_y     = c_y[k];
        cand_layer = c_layer[k];
    endtask

    // noise: scribble h/v and pulse cand_start while the block is busy
    task automatic run_txn(input bit noise);
        build_model();
        seen_rd = 0;
        seen_done = -1;
        @(posedge clk); #1;
        start_cyc = cycle_n;
        active = 1'b1;
        cand_start = 1'b1;
        h_pos = c_h;
        v_pos = c_v;
        drive_entry(0);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            cand_start = noise ? 1'($urandom % 2) : 1'b0;
            if (noise) begin
                h_pos = 10'($urandom);
                v_pos = 10'($urandom);
            end
            drive_entry(k);
        end
        for (int r = 4; r <= exp_done; r++) begin
            @(posedge clk); #1;
            cand_start = noise ? 1'($urandom % 2) : 1'b0;
            cand_id = 6'($urandom);
            cand_x = 10'($urandom);
            h_pos = 10'($urandom);
        end
        cand_start = 1'b0;
        @(negedge clk); #1;
        if (active) begin
            check("txn_timeout", 32'(active), 32'(0));
            active = 1'b0;
        end
    endtask

    task automatic set_cand(input int k, input logic [5:0] id, input logic [9:0] x,
                            input logic [9:0] y, input logic [5:0] layer);
        c_id[k] = id;
        c_x[k] = x;
        c_y[k] = y;
        c_layer[k] = layer;
    endtask

    task automatic clear_cands();
        for (int k = 0; k < 4; k++) set_cand(k, 6'h3F, 10'd0, 10'd0, 6'd0);
    endtask

    initial begin
        rst = 1'b1;
        cand_start = 1'b0;
        cand_id = 6'h3F; cand_x = 10'd0; cand_y = 10'd0; cand_layer = 6'd0;
        h_pos = 10'd0; v_pos = 10'd0;
        for (int i = 0; i < 16384; i++)
            rom_mem[i] = (($urandom % 5) < 2) ? 9'h000 : 9'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check("reset_rom_rd", 32'(rom_rd), 32'(0));
        check("reset_rom_addr", 32'(rom_addr), 32'(0));
        check("reset_valid", 32'(pixel_valid), 32'(0));
        check("reset_color", 32'(pixel_color), 32'(0));
        check("reset_hit", 32'(pixel_hit), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        rst = 1'b0;

        // single hit, with ignored starts and h/v scribbles during the run
        clear_cands();
        set_cand(0, 6'd5, 10'd100, 10'd50, 6'd2);
        c_h = 10'd103; c_v = 10'd52;
        rom_mem[14'h0523] = 9'h0A5;
        run_txn(1'b1);
        check("single_addr", 32'(seen_addr[0]), 32'h0523);
        check("single_nrd", 32'(seen_rd), 32'd1);
        check("single_latency", 32'(seen_done), 32'd6);
        check("single_color", 32'(seen_color), 32'h0A5);
        check("single_hit", 32'(seen_hit), 32'd1);

        // priority order with every texel transparent
        set_cand(0, 6'd10, 10'd100, 10'd50, 6'd7);
        set_cand(1, 6'd11, 10'd100, 10'd50, 6'd1);
        set_cand(2, 6'd12, 10'd100, 10'd50, 6'd1);
        set_cand(3, 6'd13, 10'd100, 10'd50, 6'd4);
        for (int k = 10; k < 14; k++) rom_mem[{6'(k), 4'd2, 4'd3}] = 9'h000;
        run_txn(1'b0);
        check("prio_nrd", 32'(seen_rd), 32'd4);
        check("prio_first", 32'(seen_addr[0][13:8]), 32'd11);
        check("prio_second", 32'(seen_addr[1][13:8]), 32'd12);
        check("prio_third", 32'(seen_addr[2][13:8]), 32'd13);
        check("prio_fourth", 32'(seen_addr[3][13:8]), 32'd10);
        check("alltrans_latency", 32'(seen_done), 32'd12);
        check("alltrans_hit", 32'(seen_hit), 32'd0);
        check("alltrans_color", 32'(seen_color), 32'd0);

        // out of window on both sides of x
        clear_cands();
        set_cand(0, 6'd5, 10'd100, 10'd50, 6'd2);
        c_v = 10'd52;
        for (int s = 0; s < 2; s++) begin
            c_h = (s == 0) ? 10'd99 : 10'd116;
            run_txn(1'b0);
            check("oow_nrd", 32'(seen_rd), 32'd0);
            check("oow_latency", 32'(seen_done), 32'd4);
            check("oow_hit", 32'(seen_hit), 32'd0);
        end

        // left-edge column of a sprite
        clear_cands();
        set_cand(0, 6'd5, 10'd100, 10'd50, 6'd2);
        c_h = 10'd100; c_v = 10'd53;
        rom_mem[14'h0530] = 9'h0A5;
        run_txn(1'b0);
`ifdef SPRITE_BORDER_EN
        check("border_color", 32'(seen_color), 32'h1FF);
`else
        check("border_color", 32'(seen_color), 32'h0A5);
`endif
        check("border_hit", 32'(seen_hit), 32'd1);

        // randomized transactions, some back-to-back
        for (int t = 0; t < 250; t++) begin
            c_h = 10'($urandom);
            c_v = 10'($urandom);
            for (int k = 0; k < 4; k++) begin
                c_id[k]    = (($urandom % 6) == 0) ? 6'h3F : 6'($urandom % 63);
                c_x[k]     = c_h - 10'($urandom % 20) + 10'd2;
                c_y[k]     = c_v - 10'($urandom % 20) + 10'd2;
                c_layer[k] = 6'($urandom % 6);
            end
            run_txn(1'b1);
            if (($urandom % 3) == 0) repeat ($urandom % 3) @(posedge clk);
        end

        // asynchronous reset in the middle of a fetch sequence
        set_cand(0, 6'd10, 10'd100, 10'd50, 6'd7);
        set_cand(1, 6'd11, 10'd100, 10'd50, 6'd1);
        set_cand(2, 6'd12, 10'd100, 10'd50, 6'd1);
        set_cand(3, 6'd13, 10'd100, 10'd50, 6'd4);
        c_h = 10'd103; c_v = 10'd52;
        @(posedge clk); #1;
        cand_start = 1'b1; h_pos = c_h; v_pos = c_v; drive_entry(0);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            cand_start = 1'b0;
            drive_entry(k);
        end
        @(posedge clk); #1;
        check("pre_rst_rd", 32'(rom_rd), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_rom_rd", 32'(rom_rd), 32'(0));
        check("rst_rom_addr", 32'(rom_addr), 32'(0));
        check("rst_valid", 32'(pixel_valid), 32'(0));
        check("rst_color", 32'(pixel_color), 32'(0));
        check("rst_hit", 32'(pixel_hit), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("post_rst_rd", 32'(rom_rd), 32'(0));
            check("post_rst_busy", 32'(busy), 32'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
